// File: rtl/btn_chord_frontend.sv
// rtl/btn_chord_frontend.sv - N-button sync/debounce/edge/long-press/repeat conditioner with chord events
// Shared 1 ms tick drives debounce and hold timing; all pulses are one cycle wide.
module btn_chord_frontend #(
  parameter int N_BTN         = 2,
  parameter int CLK_HZ        = 27000000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 0,
  parameter int ACTIVE_LOW    = 1,
  localparam int KW           = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic             ms_tick,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             evt_valid,
  output logic [KW-1:0]    evt_key,
  output logic [N_BTN-1:0] evt_mask
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW       = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int HMAX     = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
  localparam int HW       = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam int REP_TERM = (REPEAT_MS > 0) ? REPEAT_MS - 1 : 0;
  localparam logic [N_BTN-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT} state_t;

  logic [TW-1:0]    r_tick_cnt;
  logic [N_BTN-1:0] r_sync1, r_sync2, w_s;
  logic [DW-1:0]    r_db_cnt [N_BTN];
  logic [N_BTN-1:0] w_db_fire, w_rise, w_fall;
  state_t           r_state [N_BTN];
  state_t           w_state_nxt [N_BTN];
  logic [HW-1:0]    r_hold_cnt [N_BTN];
  logic [HW-1:0]    w_hold_cnt_nxt [N_BTN];
  logic [N_BTN-1:0] w_long_nxt, w_rep_nxt;

  assign ms_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_tick_cnt <= '0;
    else if (ms_tick) r_tick_cnt <= '0;
    else              r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= IDLE_RAW;
      r_sync2 <= IDLE_RAW;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  // Fire is computed one cycle early so the FSM sees a release on the same edge as held.
  always_comb begin
    w_db_fire = '0;
    for (int i = 0; i < N_BTN; i++)
      w_db_fire[i] = ms_tick && (w_s[i] != held[i]) && (r_db_cnt[i] == DW'(DEBOUNCE_MS - 1));
  end

  assign w_rise = w_db_fire & ~held;
  assign w_fall = w_db_fire & held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held          <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) r_db_cnt[i] <= '0;
    end else begin
      held          <= held ^ w_db_fire;
      press_pulse   <= w_rise;
      release_pulse <= w_fall;
      for (int i = 0; i < N_BTN; i++) begin
        if ((w_s[i] == held[i]) || w_db_fire[i]) r_db_cnt[i] <= '0;
        else if (ms_tick)                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_pulse   <= '0;
      repeat_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i]    <= ST_IDLE;
        r_hold_cnt[i] <= '0;
      end
    end else begin
      long_pulse   <= w_long_nxt;
      repeat_pulse <= w_rep_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i]    <= w_state_nxt[i];
        r_hold_cnt[i] <= w_hold_cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_IDLE:   if (w_rise[i]) w_state_nxt[i] = ST_WAIT;
        ST_WAIT: begin
          if (w_fall[i]) w_state_nxt[i] = ST_IDLE;
          else if (ms_tick && (r_hold_cnt[i] == HW'(LONG_PRESS_MS - 1))) w_state_nxt[i] = ST_REPEAT;
        end
        ST_REPEAT: if (w_fall[i]) w_state_nxt[i] = ST_IDLE;
        default:   w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_long_nxt = '0;
    w_rep_nxt  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_hold_cnt_nxt[i] = r_hold_cnt[i];
      case (r_state[i])
        ST_WAIT: begin
          if (w_fall[i]) w_hold_cnt_nxt[i] = '0;
          else if (ms_tick) begin
            if (r_hold_cnt[i] == HW'(LONG_PRESS_MS - 1)) begin
              w_long_nxt[i]     = 1'b1;
              w_hold_cnt_nxt[i] = '0;
            end else w_hold_cnt_nxt[i] = r_hold_cnt[i] + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (w_fall[i]) w_hold_cnt_nxt[i] = '0;
          else if ((REPEAT_MS > 0) && ms_tick) begin
            if (r_hold_cnt[i] == HW'(REP_TERM)) begin
              w_rep_nxt[i]      = 1'b1;
              w_hold_cnt_nxt[i] = '0;
            end else w_hold_cnt_nxt[i] = r_hold_cnt[i] + 1'b1;
          end
        end
        default: w_hold_cnt_nxt[i] = '0;
      endcase
    end
  end

  assign evt_valid = |press_pulse;
  assign evt_mask  = evt_valid ? held : '0;

  always_comb begin
    evt_key = '0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (press_pulse[i]) evt_key = KW'(i);
  end

endmodule
